// File: rtl/health_lives_pkg.sv
// Shared game types and defaults for the lives/invulnerability block.
package health_lives_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ALIVE     = 2'd1,
    INVULN    = 2'd2,
    GAME_OVER = 2'd3
  } state_e;

  localparam int LIVES_W           = 3;
  localparam int LIVES_INIT_DEF    = 3;
  localparam int INVULN_CYCLES_DEF = 65_000_000;

endpackage : health_lives_pkg

// File: rtl/health_lives_invuln_timer.sv
// Down-counter for the invulnerability window; load wins over count, holds at zero.
// done is a decode of the count register, no backpressure.
module invuln_timer #(
  parameter int TMR_W = 27
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [TMR_W-1:0] load_val_i,
  input  logic             en_i,
  output logic             done_o
);

  logic [TMR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - TMR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule : invuln_timer

// File: rtl/health_lives.sv
// Lives counter, invulnerability window and hit/absorb pulses driven by obstacle hits.
// All outputs registered, one cycle from sampled inputs; no backpressure.
module health_lives
  import health_lives_pkg::*;
#(
  parameter int LIVES_INIT    = LIVES_INIT_DEF,
  parameter int INVULN_CYCLES = INVULN_CYCLES_DEF,
  parameter int HIT_W         = 10,
  parameter int TMR_W         = 27
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               game_en_i,
  input  logic               game_start_i,
  input  logic [HIT_W-1:0]   hit_i,
  input  logic               is_shielded_i,
  output logic [LIVES_W-1:0] lives_o,
  output logic               invulnerable_o,
  output logic               life_lost_o,
  output logic               shield_absorbed_o,
  output logic               game_over_o
);

  localparam logic [LIVES_W-1:0] LIVES_RST  = LIVES_W'(LIVES_INIT);
  localparam logic [TMR_W-1:0]   WINDOW_TOP = TMR_W'(INVULN_CYCLES - 1);

  state_e             state_q, state_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic               life_lost_q, life_lost_d;
  logic               absorbed_q, absorbed_d;
  logic               invuln_q, game_over_q;
  logic               tmr_load, tmr_en, tmr_done;
  logic [TMR_W-1:0]   tmr_val;
  logic               any_hit;

  // Simultaneous obstacle hits are a single event.
  assign any_hit = |hit_i;
  assign tmr_en  = (state_q == INVULN) && game_en_i;

  always_comb begin
    state_d     = state_q;
    lives_d     = lives_q;
    life_lost_d = 1'b0;
    absorbed_d  = 1'b0;
    tmr_load    = 1'b0;
    tmr_val     = '0;

    if (game_start_i) begin
      state_d  = ALIVE;
      lives_d  = LIVES_RST;
      tmr_load = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: ;
        ALIVE: begin
          if (game_en_i && any_hit) begin
            if (is_shielded_i) begin
              absorbed_d = 1'b1;
              tmr_load   = 1'b1;
              tmr_val    = WINDOW_TOP;
              state_d    = INVULN;
            end else if (lives_q > LIVES_W'(1)) begin
              lives_d     = lives_q - LIVES_W'(1);
              life_lost_d = 1'b1;
              tmr_load    = 1'b1;
              tmr_val     = WINDOW_TOP;
              state_d     = INVULN;
            end else begin
              lives_d     = '0;
              life_lost_d = 1'b1;
              state_d     = GAME_OVER;
            end
          end
        end
        INVULN: begin
          if (game_en_i && tmr_done) begin
            state_d = ALIVE;
          end
        end
        GAME_OVER: lives_d = '0;
        default:   state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lives_q     <= LIVES_RST;
      life_lost_q <= 1'b0;
      absorbed_q  <= 1'b0;
      invuln_q    <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lives_q     <= lives_d;
      life_lost_q <= life_lost_d;
      absorbed_q  <= absorbed_d;
      invuln_q    <= (state_d == INVULN);
      game_over_q <= (state_d == GAME_OVER);
    end
  end

  invuln_timer #(
    .TMR_W (TMR_W)
  ) u_invuln_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .en_i       (tmr_en),
    .done_o     (tmr_done)
  );

  assign lives_o           = lives_q;
  assign invulnerable_o    = invuln_q;
  assign life_lost_o       = life_lost_q;
  assign shield_absorbed_o = absorbed_q;
  assign game_over_o       = game_over_q;

endmodule : health_lives
